// File: rtl/parity_scan_sequencer.sv
// -----------------------------------------------------------------------------
// parity_scan_sequencer
//
// Upstream sequencer for the 2-D parity checker stage. Accepts one 8x8 data
// block (8 row words, each carrying an even-parity bit, followed by a
// column-parity byte), then presents every row and every column to an external
// combinational 8-bit parity checker, one line per cycle. The returned parity
// is compared with the stored parity bits and a verdict is reported:
// clean, single-bit data error (row/column location), parity-bit-only error,
// or uncorrectable.
//
// Optional feature macro: PARITY_SCAN_CORRECT_EN
//   defined   : a single data error is corrected in storage and the verdict
//               beat is followed by 8 data beats carrying rows 0..7.
//   undefined : a single verdict beat; out_data is tied to 0.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid     input word valid
//   in_ready     block accepts input words (LOAD only)
//   in_data[7:0] words 0..7: data rows 0..7; word 8: column-parity byte
//   in_par       even-parity bit for rows 0..7 (ignored on word 8)
//   line_out     row or column vector driven to the parity checker
//   line_par_in  XOR of line_out, returned combinationally by the checker
//   out_valid    output beat valid
//   out_ready    consumer accepts beat
//   err_flag     any parity mismatch found
//   err_par      mismatch confined to a single parity bit
//   err_multi    uncorrectable pattern
//   err_row[2:0] flagged row index
//   err_col[2:0] flagged column index
//   out_data     corrected data byte (correction build only)
//   out_last     final beat of the block
// -----------------------------------------------------------------------------
module parity_scan_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_par,
  output logic [7:0] line_out,
  input  logic       line_par_in,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       err_flag,
  output logic       err_par,
  output logic       err_multi,
  output logic [2:0] err_row,
  output logic [2:0] err_col,
  output logic [7:0] out_data,
  output logic       out_last
);

  localparam logic [2:0] ST_LOAD     = 3'd0;
  localparam logic [2:0] ST_SCAN_ROW = 3'd1;
  localparam logic [2:0] ST_SCAN_COL = 3'd2;
  localparam logic [2:0] ST_EVAL     = 3'd3;  // one cycle to form the verdict
  localparam logic [2:0] ST_REPORT   = 3'd4;

  logic [2:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;          // input word count 0..8
  logic [2:0] idx_q, idx_d;          // scan index (row or column)
  logic [7:0] rows_q [8];
  logic [7:0] rows_d [8];
  logic [7:0] par_q, par_d;          // row parity bits as received
  logic [7:0] colpar_q, colpar_d;
  logic [7:0] row_err_q, row_err_d;
  logic [7:0] col_err_q, col_err_d;
  logic       flag_q, flag_d;
  logic       par_err_q, par_err_d;
  logic       multi_q, multi_d;
  logic [2:0] erow_q, erow_d;
  logic [2:0] ecol_q, ecol_d;
  logic       ready_en_q;            // keeps in_ready low until the first edge after reset
`ifdef PARITY_SCAN_CORRECT_EN
  logic [3:0] beat_q, beat_d;        // 0: verdict beat, 1..8: rows 0..7
`endif

  logic [3:0] n_row, n_col;
  logic [2:0] row_idx, col_idx;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  function automatic logic [2:0] lowest_index(input logic [7:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int i = 7; i >= 0; i--) if (v[i]) idx = 3'(i);
    return idx;
  endfunction

  assign n_row   = popcount8(row_err_q);
  assign n_col   = popcount8(col_err_q);
  assign row_idx = lowest_index(row_err_q);
  assign col_idx = lowest_index(col_err_q);

  always_comb begin
    // NOTE: every next-state variable gets a default here so that no path
    // leaves one unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    rows_d    = rows_q;
    par_d     = par_q;
    colpar_d  = colpar_q;
    row_err_d = row_err_q;
    col_err_d = col_err_q;
    flag_d    = flag_q;
    par_err_d = par_err_q;
    multi_d   = multi_q;
    erow_d    = erow_q;
    ecol_d    = ecol_q;
`ifdef PARITY_SCAN_CORRECT_EN
    beat_d    = beat_q;
`endif

    case (state_q)
      ST_LOAD: begin
        if (in_valid && in_ready) begin
          if (cnt_q == 4'd8) begin
            colpar_d = in_data;
            cnt_d    = '0;
            idx_d    = '0;
            state_d  = ST_SCAN_ROW;
          end else begin
            rows_d[cnt_q[2:0]] = in_data;
            par_d[cnt_q[2:0]]  = in_par;
            cnt_d              = cnt_q + 4'd1;
          end
        end
      end

      ST_SCAN_ROW: begin
        row_err_d[idx_q] = line_par_in ^ par_q[idx_q];
        idx_d            = idx_q + 3'd1;
        if (idx_q == 3'd7) state_d = ST_SCAN_COL;
      end

      ST_SCAN_COL: begin
        col_err_d[idx_q] = line_par_in ^ colpar_q[idx_q];
        idx_d            = idx_q + 3'd1;
        if (idx_q == 3'd7) state_d = ST_EVAL;
      end

      ST_EVAL: begin
        flag_d    = 1'b0;
        par_err_d = 1'b0;
        multi_d   = 1'b0;
        erow_d    = '0;
        ecol_d    = '0;
        if (n_row == 4'd0 && n_col == 4'd0) begin
          flag_d = 1'b0;
        end else if (n_row == 4'd1 && n_col == 4'd1) begin
          flag_d = 1'b1;
          erow_d = row_idx;
          ecol_d = col_idx;
`ifdef PARITY_SCAN_CORRECT_EN
          // Single data error: the crossing of the flagged row and column.
          rows_d[row_idx][col_idx] = ~rows_q[row_idx][col_idx];
`endif
        end else if (n_row == 4'd1 && n_col == 4'd0) begin
          flag_d    = 1'b1;
          par_err_d = 1'b1;
          erow_d    = row_idx;
        end else if (n_row == 4'd0 && n_col == 4'd1) begin
          flag_d    = 1'b1;
          par_err_d = 1'b1;
          ecol_d    = col_idx;
        end else begin
          flag_d  = 1'b1;
          multi_d = 1'b1;
        end
`ifdef PARITY_SCAN_CORRECT_EN
        beat_d  = '0;
`endif
        state_d = ST_REPORT;
      end

      ST_REPORT: begin
        if (out_ready) begin
`ifdef PARITY_SCAN_CORRECT_EN
          if (beat_q == 4'd8) begin
            state_d = ST_LOAD;
          end else begin
            beat_d = beat_q + 4'd1;
          end
`else
          state_d = ST_LOAD;
`endif
          if (state_d == ST_LOAD) begin
            flag_d    = 1'b0;
            par_err_d = 1'b0;
            multi_d   = 1'b0;
            erow_d    = '0;
            ecol_d    = '0;
          end
        end
      end

      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_LOAD;
      cnt_q      <= '0;
      idx_q      <= '0;
      // NOTE: the 8-row store is only 64 flops and a reset mid-block must
      // discard the partial block, so it is cleared along with the control.
      for (int i = 0; i < 8; i++) rows_q[i] <= '0;
      par_q      <= '0;
      colpar_q   <= '0;
      row_err_q  <= '0;
      col_err_q  <= '0;
      flag_q     <= 1'b0;
      par_err_q  <= 1'b0;
      multi_q    <= 1'b0;
      erow_q     <= '0;
      ecol_q     <= '0;
      ready_en_q <= 1'b0;
`ifdef PARITY_SCAN_CORRECT_EN
      beat_q     <= '0;
`endif
    end else begin
      // NOTE: registers take non-blocking assignments so every flop samples
      // the pre-edge value of every other flop.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      rows_q     <= rows_d;
      par_q      <= par_d;
      colpar_q   <= colpar_d;
      row_err_q  <= row_err_d;
      col_err_q  <= col_err_d;
      flag_q     <= flag_d;
      par_err_q  <= par_err_d;
      multi_q    <= multi_d;
      erow_q     <= erow_d;
      ecol_q     <= ecol_d;
      ready_en_q <= 1'b1;
`ifdef PARITY_SCAN_CORRECT_EN
      beat_q     <= beat_d;
`endif
    end
  end

  assign in_ready  = (state_q == ST_LOAD) && ready_en_q;
  assign out_valid = (state_q == ST_REPORT);
  assign err_flag  = flag_q;
  assign err_par   = par_err_q;
  assign err_multi = multi_q;
  assign err_row   = erow_q;
  assign err_col   = ecol_q;

  always_comb begin
    line_out = '0;
    if (state_q == ST_SCAN_ROW) begin
      line_out = rows_q[idx_q];
    end else if (state_q == ST_SCAN_COL) begin
      for (int r = 0; r < 8; r++) line_out[r] = rows_q[r][idx_q];
    end
  end

`ifdef PARITY_SCAN_CORRECT_EN
  assign out_last = (state_q == ST_REPORT) && (beat_q == 4'd8);
  // Beat k (1..8) carries row k-1; beat 8 wraps the 3-bit index to row 7.
  assign out_data = ((state_q == ST_REPORT) && (beat_q != 4'd0))
                    ? rows_q[3'(beat_q[2:0] - 3'd1)] : 8'h00;
`else
  assign out_last = (state_q == ST_REPORT);
  assign out_data = 8'h00;
`endif

endmodule

// File: tb/tb_parity_scan_sequencer.sv
// -----------------------------------------------------------------------------
// tb_parity_scan_sequencer
//
// Directed bench for parity_scan_sequencer. The external parity checker is
// modelled as a combinational XOR of line_out. Inputs change away from the
// rising edge; outputs are sampled #1 after a rising edge or on the falling
// edge. Build with +define+PARITY_SCAN_CORRECT_EN to cover the correction
// build.
// -----------------------------------------------------------------------------
module tb_parity_scan_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic       in_par = 1'b0;
  logic [7:0] line_out;
  logic       line_par_in;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       err_flag, err_par, err_multi;
  logic [2:0] err_row, err_col;
  logic [7:0] out_data;
  logic       out_last;

  always #5 clk = ~clk;

  parity_scan_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_par     (in_par),
    .line_out   (line_out),
    .line_par_in(line_par_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .err_flag   (err_flag),
    .err_par    (err_par),
    .err_multi  (err_multi),
    .err_row    (err_row),
    .err_col    (err_col),
    .out_data   (out_data),
    .out_last   (out_last)
  );

  assign line_par_in = ^line_out;

`ifdef PARITY_SCAN_CORRECT_EN
  localparam int NBEATS = 9;
`else
  localparam int NBEATS = 1;
`endif

  int checks   = 0;
  int failures = 0;

  logic [7:0] cur_rows [8];
  logic [7:0] cur_par;
  logic [7:0] cur_colpar;
  logic [7:0] exp_rows [8];
  logic [7:0] trace [17];
  logic [7:0] got_data [9];
  logic       got_last [9];
  logic [8:0] got_verdict [9];

  // {err_flag, err_par, err_multi, err_row, err_col}
  function automatic logic [8:0] verdict();
    return {err_flag, err_par, err_multi, err_row, err_col};
  endfunction

  function automatic logic [27:0] all_outs();
    return {in_ready, line_out, out_valid, err_flag, err_par, err_multi,
            err_row, err_col, out_data, out_last};
  endfunction

  // Clean block: row i has only bit i set, odd weight so parity 1;
  // every column holds exactly one 1, so the column byte is 0xFF.
  task automatic fill_clean();
    for (int i = 0; i < 8; i++) begin
      cur_rows[i] = 8'h01 << i;
      exp_rows[i] = 8'h01 << i;
    end
    cur_par    = 8'hFF;
    cur_colpar = 8'hFF;
  endtask

  task automatic send_word(input logic [7:0] d, input logic p, output int waited);
    waited = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_par   = p;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = '0;
    in_par   = 1'b0;
  endtask

  task automatic send_block(output int waited);
    int w;
    waited = 0;
    for (int i = 0; i < 8; i++) begin
      send_word(cur_rows[i], cur_par[i], w);
      waited += w;
    end
    send_word(cur_colpar, 1'b0, w);
    waited += w;
  endtask

  // Called #1 after the final input edge T; returns edges after T until
  // out_valid is seen (-1 if it never comes) and records line_out per cycle.
  task automatic wait_report(output int lat);
    lat = -1;
    trace[0] = line_out;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (k <= 16) trace[k] = line_out;
      if (out_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int b = 0; b < NBEATS; b++) begin
      int n;
      n = 0;
      @(negedge clk);
      while (!out_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
      got_data[b]    = out_data;
      got_last[b]    = out_last;
      got_verdict[b] = verdict();
      @(posedge clk);
    end
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    checks++;
    if (all_outs() !== 28'h0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=%h", all_outs(), 28'h0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready_before_edge got=%b exp=0", in_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready_after_edge got=%b exp=1", in_ready);
    end
  endtask

  task automatic test_clean();
    int w, lat;
    logic ok;
    fill_clean();
    send_block(w);
    checks++;
    if (w !== 0) begin
      failures++;
      $display("FAIL clean_accept_waits got=%0d exp=0", w);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL clean_ready_in_scan got=%b exp=0", in_ready);
    end
    wait_report(lat);
    checks++;
    if (lat !== 17) begin
      failures++;
      $display("FAIL clean_latency got=%0d exp=17", lat);
    end
    checks++;
    if ({trace[0], trace[3], trace[13], trace[16]} !== {8'h01, 8'h08, 8'h20, 8'h00}) begin
      failures++;
      $display("FAIL clean_line_out got=%h %h %h %h exp=01 08 20 00",
               trace[0], trace[3], trace[13], trace[16]);
    end
    checks++;
    if (verdict() !== 9'b0_0_0_000_000) begin
      failures++;
      $display("FAIL clean_verdict got=%b exp=%b", verdict(), 9'b0);
    end
    drain();
    checks++;
    if (got_last[NBEATS-1] !== 1'b1) begin
      failures++;
      $display("FAIL clean_last got=%b exp=1", got_last[NBEATS-1]);
    end
`ifdef PARITY_SCAN_CORRECT_EN
    ok = (got_data[0] === 8'h00) && (got_last[0] === 1'b0);
    for (int b = 1; b < 8; b++) if (got_last[b] !== 1'b0) ok = 1'b0;
    for (int b = 1; b <= 8; b++) if (got_data[b] !== exp_rows[b-1]) ok = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL clean_data_beats got=%h..%h exp=01..80", got_data[1], got_data[8]);
    end
`else
    ok = 1'b1;
    checks++;
    if (got_data[0] !== 8'h00 || !ok) begin
      failures++;
      $display("FAIL clean_out_data got=%h exp=00", got_data[0]);
    end
`endif
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL clean_ready_after got=%b exp=1", in_ready);
    end
  endtask

  task automatic test_single_error();
    int w, lat;
    logic ok;
    fill_clean();
    cur_rows[3] = 8'h28;  // bit 5 of row 3 flipped; stored parity kept
    send_block(w);
    wait_report(lat);
    checks++;
    if (lat !== 17) begin
      failures++;
      $display("FAIL single_latency got=%0d exp=17", lat);
    end
    checks++;
    if (verdict() !== 9'b1_0_0_011_101) begin
      failures++;
      $display("FAIL single_verdict got=%b exp=%b", verdict(), 9'b1_0_0_011_101);
    end
    drain();
    ok = 1'b1;
    for (int b = 0; b < NBEATS; b++) if (got_verdict[b] !== 9'b1_0_0_011_101) ok = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL single_verdict_stable got=%b exp=%b", got_verdict[NBEATS-1], 9'b1_0_0_011_101);
    end
`ifdef PARITY_SCAN_CORRECT_EN
    ok = 1'b1;
    for (int b = 1; b <= 8; b++) if (got_data[b] !== exp_rows[b-1]) ok = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL single_corrected_row3 got=%h exp=08", got_data[4]);
    end
`endif
  endtask

  task automatic test_par_error();
    int w, lat;
    logic ok;
    fill_clean();
    cur_par[6] = 1'b0;
    send_block(w);
    wait_report(lat);
    checks++;
    if (verdict() !== 9'b1_1_0_110_000) begin
      failures++;
      $display("FAIL par_verdict got=%b exp=%b", verdict(), 9'b1_1_0_110_000);
    end
    drain();
`ifdef PARITY_SCAN_CORRECT_EN
    ok = 1'b1;
    for (int b = 1; b <= 8; b++) if (got_data[b] !== exp_rows[b-1]) ok = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL par_data_unchanged got=%h exp=40", got_data[7]);
    end
`else
    ok = (w == 0) && (lat == 17);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL par_timing got_waits=%0d got_lat=%0d exp=0/17", w, lat);
    end
`endif
  endtask

  task automatic test_multi_error();
    int w, lat;
    logic ok;
    fill_clean();
    cur_rows[1] = 8'h03;  // bit 0 flipped in rows 1 and 2
    cur_rows[2] = 8'h05;
    exp_rows[1] = 8'h03;
    exp_rows[2] = 8'h05;
    send_block(w);
    wait_report(lat);
    checks++;
    if (verdict() !== 9'b1_0_1_000_000) begin
      failures++;
      $display("FAIL multi_verdict got=%b exp=%b", verdict(), 9'b1_0_1_000_000);
    end
    drain();
`ifdef PARITY_SCAN_CORRECT_EN
    ok = 1'b1;
    for (int b = 1; b <= 8; b++) if (got_data[b] !== exp_rows[b-1]) ok = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL multi_no_correction got=%h %h exp=03 05", got_data[2], got_data[3]);
    end
`else
    ok = (got_last[0] === 1'b1);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL multi_last got=%b exp=1", got_last[0]);
    end
`endif
  endtask

  task automatic test_back_to_back();
    int w, lat;
    logic [27:0] snap;
    logic stable;
    fill_clean();
    send_block(w);
    wait_report(lat);
    snap   = all_outs();
    stable = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (all_outs() !== snap) stable = 1'b0;
    end
    checks++;
    if (!stable || snap[27] !== 1'b0 || snap[18] !== 1'b1) begin
      failures++;
      $display("FAIL stall_stable got=%h first=%h exp_ready=0 exp_valid=1", all_outs(), snap);
    end
    drain();
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL stall_ready_after_release got=%b exp=1", in_ready);
    end
    fill_clean();
    cur_par[6] = 1'b0;
    send_block(w);
    checks++;
    if (w !== 0) begin
      failures++;
      $display("FAIL b2b_accept_waits got=%0d exp=0", w);
    end
    wait_report(lat);
    checks++;
    if (lat !== 17 || verdict() !== 9'b1_1_0_110_000) begin
      failures++;
      $display("FAIL b2b_verdict got_lat=%0d got=%b exp_lat=17 exp=%b",
               lat, verdict(), 9'b1_1_0_110_000);
    end
    drain();
  endtask

  task automatic test_reset_mid_block();
    int w, lat;
    fill_clean();
    for (int i = 0; i < 4; i++) send_word(8'hA5, 1'b0, w);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (all_outs() !== 28'h0) begin
      failures++;
      $display("FAIL midreset_outputs got=%h exp=%h", all_outs(), 28'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cur_rows[3] = 8'h28;
    send_block(w);
    wait_report(lat);
    checks++;
    if (lat !== 17 || verdict() !== 9'b1_0_0_011_101) begin
      failures++;
      $display("FAIL midreset_verdict got_lat=%0d got=%b exp_lat=17 exp=%b",
               lat, verdict(), 9'b1_0_0_011_101);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_clean();
    test_single_error();
    test_par_error();
    test_multi_error();
    test_back_to_back();
    test_reset_mid_block();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
